// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared defaults, request record and requester ids for the RF write arbiter
package rf_arb_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;
  typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_e;
endpackage

// File: rtl/rf_arb_slot.sv
// rf_arb_slot: one-entry write buffer; address-0 loads are dropped so r0 never gets written
module rf_arb_slot
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 drain_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_W-1:0]    data_i,
  output logic                 full_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [DATA_W-1:0]    data_o,
  output logic [2**ADDR_W-1:0] pend_o
);
  localparam int N = 2**ADDR_W;
  logic              full_q, full_d, take;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  assign take = load_i && (addr_i != '0);
  always_comb full_d = take ? 1'b1 : drain_i ? 1'b0 : full_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      if (take) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end
  assign full_o = full_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign pend_o = {{(N-1){1'b0}}, full_q} << addr_q;
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin merge of ALU and load writebacks onto one RF write port.
// Define RF_ARB_STATS_EN to add the saturating stall_cnt output (cycles with both slots full).
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  input  logic [DATA_W-1:0]    req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 req1_ready,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic [2**ADDR_W-1:0] pend_mask
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);
  logic                 full0, full1, grant0, grant1;
  logic [ADDR_W-1:0]    addr0, addr1;
  logic [DATA_W-1:0]    data0, data1;
  logic [2**ADDR_W-1:0] pend0, pend1;
  req_id_e              last_q, last_d;
  rf_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .rst(rst), .load_i(req0_valid & req0_ready), .drain_i(grant0),
    .addr_i(req0_addr), .data_i(req0_data), .full_o(full0), .addr_o(addr0),
    .data_o(data0), .pend_o(pend0)
  );
  rf_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .rst(rst), .load_i(req1_valid & req1_ready), .drain_i(grant1),
    .addr_i(req1_addr), .data_i(req1_data), .full_o(full1), .addr_o(addr1),
    .data_o(data1), .pend_o(pend1)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= REQ_MEM;
    else     last_q <= last_d;
  end
  // ties go to whichever requester did not win last time
  always_comb begin
    grant0 = full0 & (~full1 | (last_q == REQ_MEM));
    grant1 = full1 & (~full0 | (last_q == REQ_ALU));
    last_d = grant0 ? REQ_ALU : grant1 ? REQ_MEM : last_q;
  end
  always_comb begin
    req0_ready = ~full0 | grant0;
    req1_ready = ~full1 | grant1;
    wr_en      = grant0 | grant1;
    wr_addr    = grant0 ? addr0 : grant1 ? addr1 : '0;
    wr_data    = grant0 ? data0 : grant1 ? data1 : '0;
    pend_mask  = pend0 | pend1;
  end
`ifdef RF_ARB_STATS_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = (full0 && full1 && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
`endif
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 5, register address width (32 registers).
REQ-002 Parameter: DATA_W, default 32, register data width.
REQ-003 Clocking is decided: one clock, clk; reset rst is asynchronous and active-high.
REQ-004 Port: clk  input  1  sole clock, all state updates on posedge.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: req0_valid / req1_valid  input  1 each  write request from requester 0 (ALU writeback) / 1 (load writeback).
REQ-007 Port: req0_addr / req1_addr  input  ADDR_W each  destination register.
REQ-008 Port: req0_data / req1_data  input  DATA_W each  write data.
REQ-009 Port: req0_ready / req1_ready  output  1 each  request accepted at posedge when valid and ready are both 1.
REQ-010 Port: wr_en  output  1  register-file write enable (drives WE).
REQ-011 Port: wr_addr  output  ADDR_W  register-file write address (drives A3).
REQ-012 Port: wr_data  output  DATA_W  register-file write data (drives WD).
REQ-013 Port: pend_mask  output  2**ADDR_W  bit i set while any slot holds a write to register i.

Function
REQ-014 Each requester owns a one-entry slot {full, addr, data}; the slot loads on an accepted request.
REQ-015 Address-0 requests: accepted, then discarded; the slot is not loaded, and wr_en is never asserted for address 0.
REQ-016 Grant: combinational from slot state only; with one full slot, grant that slot; with both full, grant the slot not granted most recently.
REQ-017 Output while a grant exists: wr_en=1, wr_addr/wr_data from the granted slot; otherwise wr_en=0, wr_addr=0, wr_data=0.
REQ-018 Drain: the granted slot empties at the next posedge; the register file captures the write at that same edge.
REQ-019 Latency: request accepted at edge k produces wr_en=1 during cycle k..k+1 when uncontended; it is written at edge k+1.
REQ-020 reqN_ready = ~slotN.full | grantN; a granted slot may refill on its drain edge (one write per cycle per requester sustained).
REQ-021 Last-grant pointer updates only on a grant; no grant leaves it unchanged.
REQ-022 Same address in both slots: the slots drain in grant order; the later drain is the final value; no merging.
REQ-023 pend_mask: OR of one-hot(addr) over full slots; bit 0 always 0.
REQ-024 Neither requester is starved: a full slot is granted within 2 cycles.

Reset
REQ-025 rst=1 immediately clears both slots and forces wr_en=0, wr_addr=0, wr_data=0, pend_mask=0, reqN_ready=1.
REQ-026 Reset sets the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-027 Writes pending at reset assertion are dropped and never issued.

Configuration
REQ-028 With RF_ARB_STATS_EN defined: output stall_cnt (16 bits) counts cycles in which both slots are full; it saturates at 0xFFFF and resets to 0.
REQ-029 Without RF_ARB_STATS_EN: the stall_cnt port and its counter are absent; all other behaviour is identical.

Structure
REQ-030 Package rf_arb_pkg holds the ADDR_W/DATA_W defaults, the typedef wr_req_t {addr, data}, and the requester-id enum {REQ_ALU, REQ_MEM}.
REQ-031 Sub-module rf_arb_slot implements the one-entry slot (load, drain, full, pend one-hot); it is instantiated twice.

Verification
REQ-032 Single request: req0 addr=3 data=0xDEADBEEF at edge 1 -> wr_en=1, wr_addr=3 in cycle 1-2; reg 3 = 0xDEADBEEF after edge 2; pend_mask[3] cleared.
REQ-033 Contention: both valid from reset, addr 4 / 5, held 4 edges -> grants alternate 0,1,0,1; each slot is granted at most 2 cycles apart.
REQ-034 Zero register: req1 addr=0 data=0xFFFFFFFF -> ready=1, wr_en stays 0, pend_mask=0.
REQ-035 Same address: req0 addr=7 data=1 and req1 addr=7 data=2 on the same edge -> req0 drains first; reg 7 ends at 2.
REQ-036 Reset mid-operation: both slots full, rst pulsed between edges -> wr_en=0 asynchronously, no write issued, first tie after release goes to req0.
REQ-037 With RF_ARB_STATS_EN: 10 cycles of both slots full -> stall_cnt=10; without the macro the bench compiles without stall_cnt.
